inst_prefetch_queue: RTL
========================

Name: inst_prefetch_queue

Overview:
- Instruction-fetch front end between the instruction memory bus and the fetch stage of the pipelined datapath.
- Issues sequential word fetches on a valid/ready request channel and accepts in-order responses.
- Buffers responses with their PCs in a small FIFO and presents the head as F_inst/F_pc_current/F_pc_plus_4 under a valid/ready handshake.
- On a taken branch/jump redirect it flushes the queue and discards stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries and maximum in-flight plus buffered fetches; power of two, at least 2
PC_START, 32'h8000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (reset==0 resets)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word address of request
imem_rsp_valid  in  1  response valid; always accepted; in request order
imem_rsp_data  in  32  instruction word
F_valid  out  1  queue head valid
F_ready  in  1  fetch stage consumes head
F_inst  out  32  head instruction
F_pc_current  out  32  head PC
F_pc_plus_4  out  32  head PC + 4
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  32  new fetch PC, word aligned

Behaviour:
- State:
  - fetch_pc: next request address
  - rsp_pc: PC of the next kept response
  - FIFO of {inst, pc}, DEPTH entries, with count
  - outstanding: requests fired, response not yet received
  - drop_cnt: outstanding responses belonging to the flushed stream
- Reset:
  - fetch_pc=rsp_pc=PC_START
  - count=outstanding=drop_cnt=0
  - imem_req_valid=0, F_valid=0
- Empty-queue outputs: F_inst=32'h0000_0013 (NOP), F_pc_current=0, F_pc_plus_4=4.
- Request:
  - imem_req_valid = !redirect_valid && (count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - Fire = valid & ready. On fire, fetch_pc += 4 (32-bit wrap) and outstanding++.
  - imem_req_addr and imem_req_valid are not combinationally dependent on imem_req_ready.
- Response:
  - Each imem_rsp_valid cycle decrements outstanding.
  - If drop_cnt>0: decrement drop_cnt and discard the data.
  - Otherwise, and with no redirect this cycle: push {imem_rsp_data, rsp_pc} and rsp_pc += 4.
  - Credit rule guarantees no push to a full FIFO; a response with no matching outstanding request is a protocol error (assertion).
- Pop:
  - F_valid = (count != 0); head fields come from the FIFO output, with no combinational path from imem_rsp_*.
  - Pop on F_valid & F_ready.
  - Push and pop in the same cycle leave count unchanged, including when full.
  - Minimum latency: request fire at cycle t, response at t+1 (memory minimum), F_valid at t+2.
- Redirect (redirect_valid=1), priority over push, pop and issue:
  - FIFO cleared, count=0; pop ignored.
  - fetch_pc = rsp_pc = redirect_pc.
  - drop_cnt = outstanding - imem_rsp_valid; a response arriving in the redirect cycle is discarded.
  - F_valid=0 the following cycle.
  - Back-to-back redirects: the last one wins; drop_cnt recomputed each cycle.
- outstanding and drop_cnt are never negative and never exceed DEPTH; widths are $clog2(DEPTH)+1.
- Reset mid-operation: all state returns to reset values in one cycle. Responses arriving after reset with outstanding=0 are a protocol error; the memory side must be reset together with this block.

Test Plan:
- Reset release, memory ready=1 with 1-cycle response latency -> requests at 0x8000_0000, 0x8000_0004, ... on consecutive cycles; F_valid from cycle 2; F_pc_current 0x8000_0000 with F_pc_plus_4 0x8000_0004; steady state 1 instruction/cycle.
- F_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests fire, then imem_req_valid=0; count=4. F_ready=1 then drains in PC order and issue resumes.
- Memory latency 3 with 2 outstanding, redirect_pc=0x8000_0100 -> both old responses dropped; next F_valid entry has pc 0x8000_0100; no stale instruction seen.
- Redirect in the same cycle as a response, with 1 other request outstanding -> drop_cnt=1; first post-redirect F_inst equals the data returned for 0x8000_0100.
- imem_req_ready toggling 1,0,0,1 -> imem_req_addr held stable while not ready; no skipped or duplicated addresses.
- reset driven low with 3 entries queued -> next cycle F_valid=0, F_inst=0x0000_0013, imem_req_valid=0; after release fetch restarts at PC_START.

Source files
------------

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential word fetch, in-order response capture,
// small {inst, pc} FIFO towards the fetch stage, and redirect/flush handling
// that discards responses still in flight for the abandoned stream.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] PC_START = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        F_valid,
  input  logic        F_ready,
  output logic [31:0] F_inst,
  output logic [31:0] F_pc_current,
  output logic [31:0] F_pc_plus_4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]  DEPTH_W = DEPTH[CW:0];
  localparam logic [31:0]  NOP     = 32'h0000_0013;
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  // FIFO storage; contents are only observed while count_r says they are live
  logic [31:0] inst_mem_r [DEPTH];
  logic [31:0] pc_mem_r   [DEPTH];

  logic [31:0]   fetch_pc_r;
  logic [31:0]   rsp_pc_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_cnt_r;

  logic [CW:0]   credit_s;
  logic          req_fire_s;
  logic          drop_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] fire_inc_s;
  logic [CW-1:0] rsp_dec_s;
  logic [CW-1:0] push_inc_s;
  logic [CW-1:0] pop_dec_s;

  // Issue credit and handshake qualifiers; nothing here looks at imem_req_ready
  // except the fire term, so request valid/address stay independent of it.
  always_comb begin
    credit_s       = {1'b0, count_r} + {1'b0, outstanding_r};
    imem_req_valid = reset && !redirect_valid && (credit_s < DEPTH_W);
    imem_req_addr  = fetch_pc_r;
    req_fire_s     = imem_req_valid && imem_req_ready;
    drop_s         = imem_rsp_valid && (drop_cnt_r != ZERO_C);
    push_s         = imem_rsp_valid && (drop_cnt_r == ZERO_C) && !redirect_valid;
    pop_s          = F_valid && F_ready && !redirect_valid;
    fire_inc_s     = req_fire_s     ? ONE_C : ZERO_C;
    rsp_dec_s      = imem_rsp_valid ? ONE_C : ZERO_C;
    push_inc_s     = push_s         ? ONE_C : ZERO_C;
    pop_dec_s      = pop_s          ? ONE_C : ZERO_C;
  end

  // Head presentation: registered FIFO contents only, NOP pattern when empty.
  always_comb begin
    if (count_r != ZERO_C) begin
      F_valid      = 1'b1;
      F_inst       = inst_mem_r[rd_ptr_r];
      F_pc_current = pc_mem_r[rd_ptr_r];
      F_pc_plus_4  = pc_mem_r[rd_ptr_r] + 32'd4;
    end else begin
      F_valid      = 1'b0;
      F_inst       = NOP;
      F_pc_current = 32'h0000_0000;
      F_pc_plus_4  = 32'h0000_0004;
    end
  end

  // Control state: PCs, pointers, occupancy, in-flight and drop counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_r    <= PC_START;
      rsp_pc_r      <= PC_START;
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      count_r       <= ZERO_C;
      outstanding_r <= ZERO_C;
      drop_cnt_r    <= ZERO_C;
    end else if (redirect_valid) begin
      // Everything still in flight, minus a response landing right now,
      // belongs to the abandoned stream and must be thrown away.
      fetch_pc_r    <= redirect_pc;
      rsp_pc_r      <= redirect_pc;
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      count_r       <= ZERO_C;
      outstanding_r <= outstanding_r - rsp_dec_s;
      drop_cnt_r    <= outstanding_r - rsp_dec_s;
    end else begin
      if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      if (drop_s) begin
        drop_cnt_r <= drop_cnt_r - ONE_C;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
      if (push_s) begin
        rsp_pc_r <= rsp_pc_r + 32'd4;
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        rsp_pc_r <= rsp_pc_r;
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      outstanding_r <= outstanding_r + fire_inc_s - rsp_dec_s;
      count_r       <= count_r + push_inc_s - pop_dec_s;
    end
  end

  // FIFO data write; push is already suppressed during redirect.
  always_ff @(posedge clk) begin
    if (push_s) begin
      inst_mem_r[wr_ptr_r] <= imem_rsp_data;
      pc_mem_r[wr_ptr_r]   <= rsp_pc_r;
    end
  end

  inst_prefetch_queue_checker #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_checker (
    .clk            (clk),
    .reset          (reset),
    .imem_rsp_valid (imem_rsp_valid),
    .outstanding    (outstanding_r),
    .drop_cnt       (drop_cnt_r),
    .count          (count_r)
  );

endmodule

// Protocol and invariant checks for the prefetch queue counters.
module inst_prefetch_queue_checker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          imem_rsp_valid,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] drop_cnt,
  input logic [CW-1:0] count
);

  localparam logic [CW:0] LIMIT = DEPTH[CW:0];

  // A response must always correspond to a request still in flight.
  rsp_has_request: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (outstanding != {CW{1'b0}}));

  // In-flight count is bounded by the queue depth.
  outstanding_bound: assert property (@(posedge clk) disable iff (!reset)
    ({1'b0, outstanding} <= LIMIT));

  // Only in-flight responses can be marked for dropping.
  drop_bound: assert property (@(posedge clk) disable iff (!reset)
    (drop_cnt <= outstanding));

  // Credit rule: buffered plus in-flight never exceeds the queue depth.
  credit_bound: assert property (@(posedge clk) disable iff (!reset)
    (({1'b0, count} + {1'b0, outstanding}) <= LIMIT));

endmodule
